// File: rtl/imem_arbiter.sv
// Two-port read arbiter with an always-accepted loader write port in front of a synchronous SRAM.
// Define IMEM_ARBITER_ROUND_ROBIN_EN for round-robin contention; otherwise fetch always wins.
module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_valid,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ready,
  input  logic                  d_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_ready,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  w_valid,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  mem_en,
  output logic                  mem_r,
  output logic                  mem_w,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic prio_q, prio_d;
  logic f_rvalid_q, d_rvalid_q;
  logic f_req, d_req, f_gnt, d_gnt, wr;

  // Eligibility excludes reads that collide with this cycle's write address.
  always_comb begin
    wr     = w_valid & ~rst;
    f_req  = f_valid & ~rst & ~(w_valid && (f_addr == w_addr));
    d_req  = d_valid & ~rst & ~(w_valid && (d_addr == w_addr));
    f_gnt  = f_req & (~d_req | ~prio_q);
    d_gnt  = d_req & ~f_gnt;
    prio_d = prio_q;
    if (f_req && d_req) begin
`ifdef IMEM_ARBITER_ROUND_ROBIN_EN
      prio_d = f_gnt;
`else
      prio_d = 1'b0;
`endif
    end
  end

  always_comb begin
    f_ready   = f_gnt;
    d_ready   = d_gnt;
    mem_r     = f_gnt | d_gnt;
    mem_w     = wr;
    mem_en    = f_gnt | d_gnt | wr;
    mem_raddr = d_gnt ? d_addr : f_addr;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    f_rdata   = f_rvalid_q ? mem_rdata : '0;
    d_rdata   = d_rvalid_q ? mem_rdata : '0;
    f_rvalid  = f_rvalid_q;
    d_rvalid  = d_rvalid_q;
  end

  // Response strobes trail the grant by the SRAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      f_rvalid_q <= f_gnt;
      d_rvalid_q <= d_gnt;
    end
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL be the memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 4, SHALL be the memory word width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 f_valid / f_addr / f_ready  in / in / out  1 / ADDR_WIDTH / 1  SHALL be the fetch read request port (port 0).
REQ-006 d_valid / d_addr / d_ready  in / in / out  1 / ADDR_WIDTH / 1  SHALL be the data/debug read request port (port 1).
REQ-007 f_rvalid / f_rdata, d_rvalid / d_rdata  out  1 / DATA_WIDTH each  SHALL carry the read responses for each port.
REQ-008 w_valid / w_addr / w_data  in  1 / ADDR_WIDTH / DATA_WIDTH  SHALL be the loader write port; always accepted.
REQ-009 mem_en, mem_r, mem_w  out  1 each  SHALL drive the synchronous memory enable, read and write strobes.
REQ-010 mem_raddr, mem_waddr  out  ADDR_WIDTH  SHALL drive the memory read and write addresses.
REQ-011 mem_wdata  out  DATA_WIDTH  SHALL drive the memory write data; mem_rdata  in  DATA_WIDTH  SHALL be the registered memory read data.

Function
REQ-012 The memory SHALL be driven as a non-fall-through synchronous SRAM: read data valid on mem_rdata exactly one cycle after mem_r is sampled high.
REQ-013 At most one read port SHALL be granted per cycle; grant = ready high while valid high; ready SHALL be combinational from the current valid inputs, the arbitration state and the write port.
REQ-014 A granted read SHALL set mem_en=1, mem_r=1, mem_raddr=granted address in the same cycle.
REQ-015 The response SHALL appear exactly one cycle after grant: rvalid of the granted port high for one cycle, rdata = mem_rdata; the other port's rvalid SHALL be 0.
REQ-016 A write with w_valid=1 SHALL set mem_en=1, mem_w=1, mem_waddr=w_addr, mem_wdata=w_data in the same cycle; mem_w SHALL be 0 otherwise.
REQ-017 Read/write collision: if a read request's address equals w_addr while w_valid=1, that port's ready SHALL be 0 that cycle; the other port MAY be granted if it does not collide.
REQ-018 A read issued one cycle after a write to the same address SHALL return the new data.
REQ-019 With no granted read and no write, mem_en, mem_r and mem_w SHALL be 0.
REQ-020 Requests SHALL be pipelined: a port may be granted on consecutive cycles, giving one response per cycle.
REQ-021 A requester SHALL hold valid and addr stable until granted; the block SHALL NOT buffer ungranted requests.
REQ-022 Priority state: one-bit register prio (0 = fetch preferred), updated only when both ports request and one is granted.

Reset
REQ-023 While rst=1: f_rvalid=0, d_rvalid=0, prio=0, mem_en/mem_r/mem_w=0, f_ready=d_ready=0.
REQ-024 A read granted in the cycle rst asserts SHALL produce no response; the first grant after rst deasserts SHALL follow REQ-013.
REQ-025 rdata outputs SHALL reset to 0.

Configuration
REQ-026 Macro IMEM_ARBITER_ROUND_ROBIN_EN defined: on contention the port selected by prio wins, then prio SHALL toggle to the other port.
REQ-027 IMEM_ARBITER_ROUND_ROBIN_EN undefined: fixed priority, fetch port always wins contention; prio SHALL stay 0.

Verification
REQ-028 f_valid=1, f_addr=3, mem holds 0xA at 3 -> f_ready=1 same cycle; next cycle f_rvalid=1, f_rdata=0xA, d_rvalid=0.
REQ-029 f_valid=d_valid=1 for 4 cycles, addrs 1/2 -> RR build: grants F,D,F,D; fixed build: F,F,F,F with d_ready=0 throughout.
REQ-030 w_valid=1, w_addr=5, w_data=0x7 with d_valid=1, d_addr=5 -> d_ready=0; next cycle d granted; response 0x7.
REQ-031 w_addr=5 and f_addr=5, d_addr=6 same cycle, RR prio=0 -> f_ready=0, d_ready=1; d response next cycle; prio unchanged.
REQ-032 f granted at addr 2, rst pulsed high the following cycle -> f_rvalid=0 during and after reset; prio=0.
REQ-033 Back-to-back fetch addrs 0..7 -> eight consecutive f_rvalid pulses, data in address order.
